rr_decoder_arbiter: RTL

Round-robin scheduler that shares one downstream resource among eight requesters. Each cycle it selects a winning 3-bit index, drives it through the team's 3-to-8 decoder, and presents the result as a registered one-hot grant. It holds the grant until the owner releases it, or until an optional hold timeout expires. It sits between the requester bank and the shared resource and is the only block that drives the decoder select.

---
 rtl/arb_pkg.sv | 21 ++
 rtl/decoder_3_to_8.sv | 16 +
 rtl/rr_decoder_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// ----------------------------------------------------------------------------
// arb_pkg
//   Shared constants and the FSM state type for rr_decoder_arbiter.
//   N_REQ : number of requesters sharing the downstream resource.
//   IDX_W : width of a requester index (log2 of N_REQ).
// ----------------------------------------------------------------------------
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  // IDLE  : nobody owns the resource
  // GRANT : exactly one owner, gnt is its one-hot code
  // GAP   : single dead turnaround cycle after a grant ends
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

endpackage : arb_pkg

// File: rtl/decoder_3_to_8.sv
// ----------------------------------------------------------------------------
// decoder_3_to_8
//   Plain combinational binary-to-one-hot decoder.
//   a_i [2:0] : binary select
//   y_o [7:0] : one-hot output, y_o[a_i] = 1, all other bits 0
// ----------------------------------------------------------------------------
module decoder_3_to_8 (
  input  logic [2:0] a_i,
  output logic [7:0] y_o
);

  for (genvar gi = 0; gi < 8; gi++) begin : g_dec
    assign y_o[gi] = (a_i == 3'(gi));
  end

endmodule : decoder_3_to_8

// File: rtl/rr_decoder_arbiter.sv
// ----------------------------------------------------------------------------
// rr_decoder_arbiter
//   Round-robin scheduler for eight requesters sharing one resource. The
//   winning index is decoded by decoder_3_to_8 and registered as a one-hot
//   grant. A grant is held until the owner drops its request, followed by a
//   single dead GAP cycle before the next arbitration result is visible.
//
//   Optional feature, macro ARB_TIMEOUT_EN:
//     defined   - a saturating hold counter revokes a grant after HOLD_MAX
//                 cycles and pulses timeout for one cycle.
//     undefined - no counter, timeout is constant 0, grants are held until
//                 released. HOLD_MAX / CNT_W are still range-checked.
//
//   Parameters:
//     HOLD_MAX  maximum grant length in cycles (1 .. 2^CNT_W-1)
//     CNT_W     hold counter width
//   Ports:
//     clk        rising-edge clock
//     rst        asynchronous active-high reset
//     req  [7:0] request vector, bit i = requester i wants the resource
//     gnt  [7:0] registered one-hot grant, 0 when nobody owns the resource
//     gnt_idx    binary index of the owner, meaningful while gnt_valid = 1
//     gnt_valid  high while a grant is held
//     timeout    one-cycle pulse when the hold timer revokes a grant
// ----------------------------------------------------------------------------
module rr_decoder_arbiter
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  // Reject HOLD_MAX values the counter cannot represent.
  if (HOLD_MAX < 1 || HOLD_MAX > (1 << CNT_W) - 1) begin : g_bad_hold_max
    $error("rr_decoder_arbiter: HOLD_MAX out of range for CNT_W");
  end

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             valid_q, valid_d;
  logic             to_q, to_d;

  logic             hold_expired;
  logic [N_REQ-1:0] dec_y;

  // --------------------------------------------------------------------------
  // Rotating priority search.
  // req_rot[k] is the request of requester (last_q + 1 + k) mod 8, so the
  // lowest set bit of req_rot is the first requester found searching upward
  // from the one after the last winner. The previous winner sits at k = 7 and
  // therefore only wins when nobody else is asking.
  // --------------------------------------------------------------------------
  logic [N_REQ-1:0] req_rot;
  logic [IDX_W-1:0] win_ofs;
  logic [IDX_W-1:0] win_idx;
  logic             win_found;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
    assign req_rot[gi] = req[last_q + IDX_W'(gi + 1)];
  end

  // Scan from the top down so the lowest set offset is the one left standing.
  always_comb begin
    win_found = 1'b0;
    win_ofs   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        win_found = 1'b1;
        win_ofs   = IDX_W'(k);
      end
    end
  end

  // 3-bit arithmetic wraps 7 -> 0 naturally.
  assign win_idx = last_q + IDX_W'(1) + win_ofs;

  // --------------------------------------------------------------------------
  // Optional hold timer
  // --------------------------------------------------------------------------
`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign hold_expired = (cnt_q == HOLD_LIM);

  // Loads 1 on entry to GRANT, counts while the grant is kept, saturates.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q != GRANT && state_d == GRANT) begin
      cnt_d = CNT_W'(1);
    end else if (state_q == GRANT && state_d == GRANT && cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign hold_expired = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    to_d    = 1'b0;

    unique case (state_q)
      IDLE, GAP: begin
        if (win_found) begin
          state_d = GRANT;
          idx_d   = win_idx;
          last_d  = win_idx;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        // Release is tested first so a simultaneous release never reports
        // a timeout. Other requesters' bits are ignored here.
        if (!req[idx_q]) begin
          state_d = GAP;
        end else if (hold_expired) begin
          state_d = GAP;
          to_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    valid_d = (state_d == GRANT);
  end

  // The decoder sees the next owner index; its output is only registered
  // into gnt when the next state actually holds a grant.
  decoder_3_to_8 u_dec (
    .a_i (idx_d),
    .y_o (dec_y)
  );

  assign gnt_d = valid_d ? dec_y : '0;

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= IDX_W'(N_REQ - 1);   // first search starts at requester 0
      idx_q   <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      to_q    <= to_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;
  assign timeout   = to_q;

endmodule : rr_decoder_arbiter
